// File: rtl/vpll_manager_pkg.sv
// Shared definitions for the video PLL sequencer: state encoding and the
// MANAGE_VPLL bit layout.
package vpll_manager_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TEST    = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_FAILED  = 3'd5
    } vpll_state_e;

    localparam int unsigned MV_USE  = 1;
    localparam int unsigned MV_TEST = 0;

    // MANAGE_VPLL value driven while in a given state; never both bits set.
    function automatic logic [1:0] manage_of(input vpll_state_e s);
        logic [1:0] m;
        m = '0;
        case (s)
            ST_TEST, ST_CONFIRM: m[MV_TEST] = 1'b1;
            ST_RUN:              m[MV_USE]  = 1'b1;
            default:             m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vpll_manager_sync_2ff.sv
// Generic single-bit two-flop synchroniser, synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/vpll_manager.sv
// Video PLL sequencer: releases the PLL, waits for a stable lock, switches the
// Tx path to it, and falls back/retries on lock loss.
module vpll_manager
    import vpll_manager_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT   = 1024,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned HOLDOFF_CYCLES = 64,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST,
    input  logic       REQ_75M,
    input  logic       VCLK_PLL_LOCKED,
    output logic [1:0] MANAGE_VPLL,
    output logic       VPLL_FAIL,
    output logic [2:0] VPLL_STATE
);

    localparam int unsigned CNT_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > HOLDOFF_CYCLES) ? CNT_MAX_A : HOLDOFF_CYCLES;
    localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SC_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HC_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRIES);

    logic          lock_s;
    vpll_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retry_q, retry_d;
    logic [2:0]    retry_inc;
    logic          enter_hold;
    logic [1:0]    manage_q;
    logic          fail_q;

    sync_2ff u_lock_sync (
        .clk_i (SYS_CLK),
        .rst_i (SYS_RST),
        .d_i   (VCLK_PLL_LOCKED),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        enter_hold = 1'b0;
        retry_inc  = (retry_q >= RETRY_MAX) ? retry_q : retry_q + 3'd1;

        if (!REQ_75M) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TEST;
                    cnt_d   = '0;
                end
                ST_TEST: begin
                    if (lock_s) begin
                        state_d = ST_CONFIRM;
                        cnt_d   = '0;
                    end else if (cnt_q == LT_LAST) begin
                        enter_hold = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (!lock_s) begin
                        enter_hold = 1'b1;
                    end else if (cnt_q == SC_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) enter_hold = 1'b1;
                end
                ST_HOLDOFF: begin
                    if (cnt_q == HC_LAST) begin
                        state_d = ST_TEST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FAILED: state_d = ST_FAILED;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // A failed attempt bumps the retry count; the last allowed one goes straight to FAILED.
            if (enter_hold) begin
                cnt_d   = '0;
                retry_d = retry_inc;
                state_d = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_HOLDOFF;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            manage_q <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            manage_q <= manage_of(state_d);
            fail_q   <= (state_d == ST_FAILED);
        end
    end

    assign MANAGE_VPLL = manage_q;
    assign VPLL_FAIL   = fail_q;
    assign VPLL_STATE  = state_q;

endmodule
